matrix_result_drain: RTL
========================

# matrix_result_drain

Drain side of the matrix accelerator. Sits between the CORE_COUNT dot-product cores and the result memory, opposite the address/control sequencer. Captures all core accumulators in parallel at the end of each output-row pass, then serialises them as single-word writes to the result memory over a valid/ready handshake. Signals run completion once the last captured word is written.

## Interface
Parameters:
- CORE_COUNT, 4, number of parallel cores; one result word per core per capture
- DATA_W, 32, width of one core accumulator / result word
- ADDR_W, 10, result-memory word address width

Ports:
- CLOCK_25  in  1  sole clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_core_rst  in  1  core clear from the sequencer; a 0→1 transition marks end of a dot-product pass
- i_row_adr_pipe  in  5  output row of the pass that just ended
- i_core_column_pipe  in  5  first output column covered by core 0 for that pass
- i_s_matrix_column_size  in  8  result matrix column count (row stride)
- i_core_data  in  CORE_COUNT*DATA_W  accumulators; core k at bits [k*DATA_W +: DATA_W]
- i_finished  in  1  sequencer idle flag
- o_wr_en  out  1  write request valid
- o_wr_adr  out  ADDR_W  write address
- o_wr_data  out  DATA_W  write data
- i_wr_ready  in  1  memory accepts the write this cycle
- o_busy  out  1  capture buffer holds undrained words
- o_overflow  out  1  sticky; a capture was dropped
- o_done  out  1  one-cycle run-complete pulse

## Operation
- Edge detect: register i_core_rst into core_rst_q. Capture event = i_core_rst & ~core_rst_q. Finish event = i_finished & ~fin_q. Start event = ~i_finished & fin_q.
- Capture:
  - Latch all CORE_COUNT words, row, column and stride into the buffer.
  - n = min(CORE_COUNT, stride − column), computed 9-bit unsigned. If column ≥ stride, n = 0.
  - Base = row*stride + column, computed 13-bit, truncated to ADDR_W.
- States:
  - IDLE:
    - Capture with n > 0 → DRAIN, k = 0.
    - Capture with n = 0 → stay IDLE; no writes, no overflow.
  - DRAIN:
    - o_wr_en = 1, o_wr_adr = base + k, o_wr_data = word k.
    - A transfer occurs on o_wr_en & i_wr_ready. Each transfer increments k.
    - The transfer with k = n−1 → IDLE.
    - Address, data and o_wr_en stay stable while i_wr_ready = 0.
  - DONE_PEND: entered from DRAIN after the last transfer if a finish event arrived during DRAIN. Emits o_done next cycle, then → IDLE.
- Capture during DRAIN:
  - If it coincides with the final transfer (k = n−1 accepted same cycle), it is accepted: buffer reloads, k = 0, stay DRAIN.
  - Otherwise it is dropped and o_overflow ← 1.
- Finish event:
  - In IDLE: o_done pulses the next cycle.
  - In DRAIN: a pending flag is set; o_done pulses one cycle after the final transfer.
- Start event clears o_overflow and the pending flag.
- o_busy = (state == DRAIN).

## Timing
- Reset (async assert, sync release): state IDLE, k = 0, all edge registers 0. o_wr_en, o_wr_adr, o_wr_data, o_busy, o_overflow, o_done all 0.
- Capture event in cycle N → o_wr_en = 1 with word 0 from cycle N+1.
- With i_wr_ready held 1, word k is presented in cycle N+1+k. o_wr_en drops in cycle N+1+n.
- Each cycle i_wr_ready is low stretches the drain by one cycle.
- Reset asserted mid-drain: remaining words are discarded; no further writes after release.
- i_core_data is sampled only in the capture cycle; later changes do not affect queued words.

## Test plan
- CORE_COUNT=4, stride 8, row 2, column 4, ready tied 1, capture in cycle 10 with words 0xA0..0xA3 → writes to addresses 20, 21, 22, 23 in cycles 11–14; o_busy high for cycles 11–14.
- Stride 6, column 4 → n = 2: only addresses row*6+4 and row*6+5 are written. Column 8, stride 6 → no writes and o_overflow stays 0.
- Ready toggles 1,0,0,1,… during a drain → each word held stable until accepted; order and addresses unchanged; 4 transfers total.
- Second capture arrives while k = 1 → o_overflow = 1, only the first set is written. A second capture coinciding with acceptance of word 3 → accepted; 8 contiguous writes with no gap; o_overflow stays 0.
- i_finished rises while k = 2 → o_done pulses exactly one cycle, the cycle after word 3 is accepted. i_finished rises while IDLE → o_done in the next cycle. i_finished falls → o_overflow clears.
- i_rst_n pulsed low mid-drain → all outputs 0 immediately (asynchronous); after release, no writes until the next capture event.

Source files
------------

// File: rtl/matrix_result_drain.sv
// Drain side of the matrix accelerator. Captures all core accumulators at the end of a pass
// and serialises them as single-word result-memory writes over a valid/ready handshake.
module matrix_result_drain #(
  parameter int CORE_COUNT = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10
) (
  input  logic                         CLOCK_25,
  input  logic                         i_rst_n,
  input  logic                         i_core_rst,
  input  logic [4:0]                   i_row_adr_pipe,
  input  logic [4:0]                   i_core_column_pipe,
  input  logic [7:0]                   i_s_matrix_column_size,
  input  logic [CORE_COUNT*DATA_W-1:0] i_core_data,
  input  logic                         i_finished,
  output logic                         o_wr_en,
  output logic [ADDR_W-1:0]            o_wr_adr,
  output logic [DATA_W-1:0]            o_wr_data,
  input  logic                         i_wr_ready,
  output logic                         o_busy,
  output logic                         o_overflow,
  output logic                         o_done
);
  // state     | meaning
  // IDLE      | buffer empty, waiting for a capture
  // DRAIN     | presenting buffered word k to the result memory
  // DONE_PEND | drain ended with a finish seen during it; o_done high this cycle

  localparam int KW  = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int KW1 = KW + 1;
  localparam logic [8:0] CC9 = 9'(CORE_COUNT);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE_PEND} state_t;

  state_t            state_q;
  logic              core_rst_q;
  logic              fin_q;
  logic              pend_q;
  logic [KW-1:0]     k_q;
  logic [KW:0]       n_q;
  logic [DATA_W-1:0] word_q [CORE_COUNT];

  logic              cap_ev;
  logic              fin_ev;
  logic              start_ev;
  logic              xfer_c;
  logic              last_c;
  logic              accept_c;
  logic [8:0]        diff_c;
  logic [8:0]        n_full_c;
  logic [KW:0]       n_c;
  logic [12:0]       base_full_c;
  logic [ADDR_W-1:0] base_c;

  always_comb begin
    cap_ev   = i_core_rst & ~core_rst_q;
    fin_ev   = i_finished & ~fin_q;
    start_ev = ~i_finished & fin_q;
    diff_c   = {1'b0, i_s_matrix_column_size} - {4'b0, i_core_column_pipe};
    if ({3'b0, i_core_column_pipe} >= i_s_matrix_column_size)
      n_full_c = '0;
    else if (diff_c > CC9)
      n_full_c = CC9;
    else
      n_full_c = diff_c;
    n_c         = KW1'(n_full_c);
    base_full_c = 13'(i_row_adr_pipe) * 13'(i_s_matrix_column_size)
                + 13'(i_core_column_pipe);
    base_c      = ADDR_W'(base_full_c);
    xfer_c      = (state_q == DRAIN) & i_wr_ready;
    last_c      = (({1'b0, k_q} + KW1'(1)) == n_q);
    // a capture landing on the final accepted word reloads the buffer without a gap
    accept_c    = cap_ev & (n_c != '0) & ((state_q != DRAIN) | (xfer_c & last_c));
  end

  always_ff @(posedge CLOCK_25) begin
    if (accept_c)
      for (int i = 0; i < CORE_COUNT; i++)
        word_q[i] <= i_core_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge CLOCK_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      core_rst_q <= 1'b0;
      fin_q      <= 1'b0;
      pend_q     <= 1'b0;
      k_q        <= '0;
      n_q        <= '0;
      o_wr_en    <= 1'b0;
      o_wr_adr   <= '0;
      o_wr_data  <= '0;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      core_rst_q <= i_core_rst;
      fin_q      <= i_finished;
      o_done     <= 1'b0;
      if (start_ev) begin
        o_overflow <= 1'b0;
        pend_q     <= 1'b0;
      end
      if (accept_c) begin
        state_q   <= DRAIN;
        k_q       <= '0;
        n_q       <= n_c;
        o_wr_en   <= 1'b1;
        o_wr_adr  <= base_c;
        o_wr_data <= i_core_data[DATA_W-1:0];
      end
      case (state_q)
        IDLE: o_done <= fin_ev;
        DONE_PEND: if (!accept_c) state_q <= IDLE;
        DRAIN: begin
          if (fin_ev) pend_q <= 1'b1;
          if (cap_ev && !(xfer_c && last_c)) o_overflow <= 1'b1;
          if (xfer_c) begin
            if (!last_c) begin
              k_q       <= k_q + KW'(1);
              o_wr_adr  <= o_wr_adr + ADDR_W'(1);
              o_wr_data <= word_q[k_q + KW'(1)];
            end else if (!accept_c) begin
              o_wr_en <= 1'b0;
              pend_q  <= 1'b0;
              if (pend_q || fin_ev) begin
                state_q <= DONE_PEND;
                o_done  <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy = (state_q == DRAIN);

endmodule
